// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver. Digits are snapshotted once per
// scan frame; anode, segment and decimal-point lines are active-low and
// registered one cycle behind the scan index.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  input  logic        blink_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_FRAMES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
  logic            phase_on_q, phase_on_d;
  logic [3:0]      an_d;
  logic [6:0]      seg_d;
  logic            dp_d;

  logic            cnt_last;
  logic            wrap;
  logic [3:0]      lz_blank;
  logic [3:0]      cur_digit;
  logic [6:0]      cur_seg;

  assign cnt_last = (cnt_q == CntLast);
  assign wrap     = cnt_last && (idx_q == 2'd3);

  // Scan counter, digit index, frame snapshot and blink timing.
  always_comb begin
    cnt_d      = cnt_last ? '0 : cnt_q + CntW'(1);
    idx_d      = cnt_last ? idx_q + 2'd1 : idx_q;
    shadow_d   = wrap ? digits : shadow_q;
    blk_cnt_d  = blk_cnt_q;
    phase_on_d = phase_on_q;
    if (wrap) begin
      if (blk_cnt_q == BlkLast) begin
        blk_cnt_d  = '0;
        phase_on_d = ~phase_on_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BlkW'(1);
      end
    end
  end

  // Leading-zero blanking cascades down from the thousands digit; ones never blank.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = blank_lz && (shadow_q[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (shadow_q[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (shadow_q[7:4] == 4'd0);
  end

  // Select the digit under scan and decode it; codes A-F render as a dash.
  always_comb begin
    cur_digit = shadow_q[3:0];
    case (idx_q)
      2'd0:    cur_digit = shadow_q[3:0];
      2'd1:    cur_digit = shadow_q[7:4];
      2'd2:    cur_digit = shadow_q[11:8];
      default: cur_digit = shadow_q[15:12];
    endcase
    case (cur_digit)
      4'd0:    cur_seg = 7'b1000000;
      4'd1:    cur_seg = 7'b1111001;
      4'd2:    cur_seg = 7'b0100100;
      4'd3:    cur_seg = 7'b0110000;
      4'd4:    cur_seg = 7'b0011001;
      4'd5:    cur_seg = 7'b0010010;
      4'd6:    cur_seg = 7'b0000010;
      4'd7:    cur_seg = 7'b1111000;
      4'd8:    cur_seg = 7'b0000000;
      4'd9:    cur_seg = 7'b0010000;
      default: cur_seg = 7'b0111111;
    endcase
  end

  // Next output values; blink off phase darkens everything including dp.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!(blink_en && !phase_on_q)) begin
      an_d = ~(4'b0001 << idx_q);
      if (!lz_blank[idx_q]) begin
        seg_d = cur_seg;
      end
      dp_d = ~dp_mask[idx_q];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      shadow_q   <= 16'h0000;
      blk_cnt_q  <= '0;
      phase_on_q <= 1'b1;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      blk_cnt_q  <= blk_cnt_d;
      phase_on_q <= phase_on_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-level arithmetic reference model plus a
// table of hand-decoded frames and directed snapshot/blink/reset sequences.
module tb_seg7_scan_driver;

  localparam int unsigned R  = 4;
  localparam int unsigned BF = 2;
  localparam int unsigned FR = 4 * R;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits = 16'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_mask = 4'h0;
  logic        blink_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan_driver #(
    .REFRESH_DIV (R),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits    (digits),
    .blank_lz  (blank_lz),
    .dp_mask   (dp_mask),
    .blink_en  (blink_en),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned n       = 0;       // clock edges since reset release
  logic [15:0] shadow_m = 16'h0;  // model snapshot
  logic [6:0]  seg_lut [16];

  typedef struct {
    logic [15:0] digits;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [27:0] seg_exp;  // {d3,d2,d1,d0}
    logic [3:0]  dp_exp;   // bit i = dp line while digit i active
  } vec_t;

  vec_t       tbl [8];
  logic [3:0] an_exp [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // One clock edge, checked against the model.
  task automatic step_check();
    int unsigned idx, w;
    logic        on, blank, exp_ft;
    logic [3:0]  e_an, d;
    logic [6:0]  e_seg;
    logic        e_dp;
    idx   = (n / R) % 4;
    w     = n / FR;
    on    = ((w / BF) % 2) == 0;
    d     = shadow_m[4*idx +: 4];
    blank = blank_lz && (idx != 0) && ((shadow_m >> (4 * idx)) == 16'h0);
    if (blink_en && !on) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << idx);
      e_seg = blank ? 7'h7F : seg_lut[d];
      e_dp  = ~dp_mask[idx];
    end
    @(posedge clk);
    n++;
    exp_ft = (n % FR) == 0;
    if (exp_ft) shadow_m = digits;
    #1;
    chk("model an", 32'(an), 32'(e_an));
    chk("model seg", 32'(seg), 32'(e_seg));
    chk("model dp", 32'(dp), 32'(e_dp));
    chk("model frame_tick", 32'(frame_tick), 32'(exp_ft));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    digits   = 16'($urandom);
    blank_lz = 1'($urandom);
    dp_mask  = 4'($urandom);
    blink_en = 1'($urandom);
    #1;
    chk("reset an", 32'(an), 32'h0000000F);
    chk("reset seg", 32'(seg), 32'h0000007F);
    chk("reset dp", 32'(dp), 32'h00000001);
    chk("reset frame_tick", 32'(frame_tick), 32'h00000000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset held an", 32'(an), 32'h0000000F);
    @(negedge clk);
    rst      = 1'b0;
    n        = 0;
    shadow_m = 16'h0;
  endtask

  task automatic wait_ft();
    for (int i = 0; i < 2 * FR; i++) begin
      step_check();
      if (frame_tick === 1'b1) return;
    end
    chk("wait_ft timeout", 32'h0, 32'h1);
  endtask

  initial begin
    seg_lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tbl[0] = '{16'h1234, 1'b0, 4'b0000,
               {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
    tbl[1] = '{16'h0050, 1'b1, 4'b0000,
               {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
    tbl[2] = '{16'h0000, 1'b1, 4'b0000,
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    tbl[3] = '{16'h0000, 1'b0, 4'b0000,
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
    tbl[4] = '{16'h00A0, 1'b0, 4'b0010,
               {7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000}, 4'b1101};
    tbl[5] = '{16'h0050, 1'b1, 4'b1000,
               {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b0111};
    tbl[6] = '{16'h5678, 1'b0, 4'b0000,
               {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b1111};
    tbl[7] = '{16'hF9A0, 1'b1, 4'b0101,
               {7'b0111111, 7'b0010000, 7'b0111111, 7'b1000000}, 4'b1010};

    #2;
    do_reset();
    blink_en = 1'b0;
    step_check();
    chk("first an", 32'(an), 32'h0000000E);
    chk("first seg", 32'(seg), 32'h00000040);

    // Table-driven frames: load inputs, wait for the snapshot, check each digit slot.
    for (int t = 0; t < 8; t++) begin
      digits   = tbl[t].digits;
      blank_lz = tbl[t].blank_lz;
      dp_mask  = tbl[t].dp_mask;
      wait_ft();
      for (int j = 1; j <= int'(FR); j++) begin
        step_check();
        if (((j - 1) % R) == 1) begin
          int k;
          k = (j - 1) / R;
          chk($sformatf("tbl%0d an d%0d", t, k), 32'(an), 32'(an_exp[k]));
          chk($sformatf("tbl%0d seg d%0d", t, k), 32'(seg), 32'(tbl[t].seg_exp[7*k +: 7]));
          chk($sformatf("tbl%0d dp d%0d", t, k), 32'(dp), 32'(tbl[t].dp_exp[k]));
        end
      end
    end

    // Mid-frame digit change stays hidden until the next snapshot.
    digits = 16'h1234; blank_lz = 1'b0; dp_mask = 4'h0;
    wait_ft();
    for (int j = 1; j <= int'(2 * R + 1); j++) step_check();
    digits = 16'h5678;
    for (int j = 2 * R + 2; j <= int'(FR); j++) begin
      step_check();
      if (j == int'(3 * R + 2)) chk("snap old thousands", 32'(seg), 32'(7'b1111001));
    end
    chk("snap frame_tick", 32'(frame_tick), 32'h1);
    step_check();
    chk("snap new an", 32'(an), 32'h0000000E);
    chk("snap new seg", 32'(seg), 32'(7'b0000000));

    // Blink: frames 1-2 lit, 3-4 dark, 5-6 lit, 7 dark; reset pulse in the dark phase.
    do_reset();
    digits = 16'h1234; blank_lz = 1'b0; dp_mask = 4'hF; blink_en = 1'b1;
    for (int f = 1; f <= 7; f++) begin
      while (n < (f - 1) * FR + 2) step_check();
      if (f == 3 || f == 4 || f == 7) begin
        chk($sformatf("blink f%0d an", f), 32'(an), 32'h0000000F);
        chk($sformatf("blink f%0d dp", f), 32'(dp), 32'h00000001);
      end else begin
        chk($sformatf("blink f%0d an", f), 32'(an), 32'h0000000E);
      end
    end
    do_reset();
    digits = 16'h1234; blink_en = 1'b1;
    step_check();
    chk("blink reset an", 32'(an), 32'h0000000E);

    // Randomized traffic against the model, with one reset mid-run.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 4; k++)
          digits[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom);
        dp_mask  = 4'($urandom);
        blink_en = ($urandom_range(0, 3) == 0);
      end
      if (c == 700) do_reset();
      step_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
